// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared core constants and pipeline-boundary record types.
// Revision : 1.0
// ============================================================================
package core_pkg;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        full;
    } skid_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid
// Brief    : One-entry buffer holding a ROM response that arrived while decode stalled.
// Revision : 1.0
// ============================================================================
module fetch_skid
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_capture,
    input  logic        i_drain,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output skid_t       o_skid
);

    skid_t r_skid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_skid <= '0;
        end else if (i_capture) begin
            r_skid <= '{instr: i_instr, pc: i_pc, full: 1'b1};
        end else if (i_drain) begin
            r_skid.full <= 1'b0;
        end
    end

    assign o_skid = r_skid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Fetch PC, synchronous ROM issue and IF/ID register with stall/redirect.
// Revision : 1.0
// ============================================================================
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        ImemEn,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [31:0] r_pcf;
    logic [31:0] r_pend_pc;
    logic        r_pending;
    if_id_t      r_ifid;
    skid_t       w_skid;

    logic        w_issue;
    logic        w_capture;
    logic        w_drain;
    logic [31:0] w_redirect_pc;

    assign w_issue       = !rst && !StallD && !Redirect;
    assign w_capture     = StallD && !Redirect && r_pending;
    assign w_drain       = !StallD && !Redirect && w_skid.full;
    assign w_redirect_pc = RedirectTarget & ~32'h0000_0003;

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (Redirect),
        .i_capture (w_capture),
        .i_drain   (w_drain),
        .i_instr   (ImemRData),
        .i_pc      (r_pend_pc),
        .o_skid    (w_skid)
    );

    // A redirect drops whatever response is in flight; pending clears because no issue happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf     <= RESET_PC;
            r_pend_pc <= '0;
            r_pending <= 1'b0;
            r_ifid    <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pcf     <= r_pcf + 32'd4;
                r_pend_pc <= r_pcf;
            end

            if (Redirect) begin
                r_pcf        <= w_redirect_pc;
                r_ifid.valid <= 1'b0;
                r_ifid.instr <= NOP_INSTR;
            end else if (!StallD) begin
                if (w_skid.full) begin
                    r_ifid <= '{instr: w_skid.instr, pc: w_skid.pc,
                                pc_plus4: w_skid.pc + 32'd4, valid: 1'b1};
                end else if (r_pending) begin
                    r_ifid <= '{instr: ImemRData, pc: r_pend_pc,
                                pc_plus4: r_pend_pc + 32'd4, valid: 1'b1};
                end else begin
                    r_ifid.valid <= 1'b0;
                    r_ifid.instr <= NOP_INSTR;
                end
            end
        end
    end

    assign ImemEn   = w_issue;
    assign ImemAddr = r_pcf;
    assign InstrD   = r_ifid.instr;
    assign PCD      = r_ifid.pc;
    assign PCPlus4D = r_ifid.pc_plus4;
    assign ValidD   = r_ifid.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Cycle table plus in-order scoreboard for the fetch stage.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic        N       = 1'b0;
    localparam logic        Y       = 1'b1;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_RSTPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallD = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'h0;
    logic        ImemEn;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRData = 32'h0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .StallD         (StallD),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .ImemEn         (ImemEn),
        .ImemAddr       (ImemAddr),
        .ImemRData      (ImemRData),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    // ROM content: word at address a is a+1 (ROM[i] = i*4+1).
    always @(posedge clk) begin
        if (ImemEn) ImemRData <= ImemAddr + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } sb_t;

    sb_t         q[$];
    logic [31:0] m_pc  = c_RSTPC;
    logic        m_upd = 1'b0;

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            q.delete();
            m_pc  = c_RSTPC;
            m_upd = 1'b0;
        end else begin
            if (m_upd && ValidD) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h expected no valid instruction", PCD);
                end else begin
                    e = q.pop_front();
                    chk("sb_instr", InstrD, e.instr);
                    chk("sb_pc", PCD, e.pc);
                    chk("sb_pc4", PCPlus4D, e.pc4);
                end
            end
            chk("sb_addr", ImemAddr, m_pc);
            chk("sb_en", {31'b0, ImemEn}, {31'b0, !StallD && !Redirect});
            if (!StallD && !Redirect) begin
                q.push_back('{instr: m_pc + 32'd1, pc: m_pc, pc4: m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
            if (Redirect) begin
                q.delete();
                m_pc = RedirectTarget & ~32'h0000_0003;
            end
            m_upd = !StallD || Redirect;
            if (!StallD) begin
                chk("inv_skid_pending",
                    {31'b0, u_dut.u_skid.r_skid.full && u_dut.r_pending}, 32'h0);
            end
        end
    end

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        r, s, d;
        logic [31:0] t;
        logic        en;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr, pc, pc4;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] t,
                                input logic en, input logic [31:0] addr, input logic v,
                                input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] pc4);
        vec_t x;
        x.r = r; x.s = s; x.d = d; x.t = t; x.en = en; x.addr = addr;
        x.v = v; x.instr = instr; x.pc = pc; x.pc4 = pc4;
        return x;
    endfunction

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r; StallD = s; Redirect = d; RedirectTarget = t;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [31:0] addr,
                           input logic v, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] pc4);
        chk({tag, "_en"}, {31'b0, ImemEn}, {31'b0, en});
        chk({tag, "_addr"}, ImemAddr, addr);
        chk({tag, "_valid"}, {31'b0, ValidD}, {31'b0, v});
        chk({tag, "_instr"}, InstrD, instr);
        chk({tag, "_pc"}, PCD, pc);
        chk({tag, "_pc4"}, PCPlus4D, pc4);
    endtask

    initial begin
        //               r  s  d  target         en addr           v  instr          pc             pc4
        tbl[0]  = mk(Y, N, N, 32'h0,        N, 32'h0,        N, c_NOP,         32'h0,         32'h0);
        tbl[1]  = mk(Y, N, N, 32'h0,        N, 32'h0,        N, c_NOP,         32'h0,         32'h0);
        tbl[2]  = mk(N, N, N, 32'h0,        Y, 32'h0,        N, c_NOP,         32'h0,         32'h0);
        tbl[3]  = mk(N, N, N, 32'h0,        Y, 32'h4,        N, c_NOP,         32'h0,         32'h0);
        tbl[4]  = mk(N, N, N, 32'h0,        Y, 32'h8,        Y, 32'h1,         32'h0,         32'h4);
        tbl[5]  = mk(N, Y, N, 32'h0,        N, 32'hC,        Y, 32'h5,         32'h4,         32'h8);
        tbl[6]  = mk(N, Y, N, 32'h0,        N, 32'hC,        Y, 32'h5,         32'h4,         32'h8);
        tbl[7]  = mk(N, Y, N, 32'h0,        N, 32'hC,        Y, 32'h5,         32'h4,         32'h8);
        tbl[8]  = mk(N, N, N, 32'h0,        Y, 32'hC,        Y, 32'h5,         32'h4,         32'h8);
        tbl[9]  = mk(N, N, N, 32'h0,        Y, 32'h10,       Y, 32'h9,         32'h8,         32'hC);
        tbl[10] = mk(N, N, N, 32'h0,        Y, 32'h14,       Y, 32'hD,         32'hC,         32'h10);
        tbl[11] = mk(N, Y, Y, 32'h102,      N, 32'h18,       Y, 32'h11,        32'h10,        32'h14);
        tbl[12] = mk(N, N, N, 32'h0,        Y, 32'h100,      N, c_NOP,         32'h10,        32'h14);
        tbl[13] = mk(N, N, N, 32'h0,        Y, 32'h104,      N, c_NOP,         32'h10,        32'h14);
        tbl[14] = mk(N, Y, N, 32'h0,        N, 32'h108,      Y, 32'h101,       32'h100,       32'h104);
        tbl[15] = mk(N, Y, Y, 32'h200,      N, 32'h108,      Y, 32'h101,       32'h100,       32'h104);
        tbl[16] = mk(N, N, N, 32'h0,        Y, 32'h200,      N, c_NOP,         32'h100,       32'h104);
        tbl[17] = mk(N, N, N, 32'h0,        Y, 32'h204,      N, c_NOP,         32'h100,       32'h104);
        tbl[18] = mk(N, N, N, 32'h0,        Y, 32'h208,      Y, 32'h201,       32'h200,       32'h204);
        tbl[19] = mk(N, N, N, 32'h0,        Y, 32'h20C,      Y, 32'h205,       32'h204,       32'h208);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].t);
            chk_out($sformatf("row%0d", i), tbl[i].en, tbl[i].addr, tbl[i].v,
                    tbl[i].instr, tbl[i].pc, tbl[i].pc4);
        end

        // PC wrap at the top of the address space
        step(N, N, Y, 32'hFFFF_FFFC);
        chk_out("wrap_redir", N, 32'h210, Y, 32'h209, 32'h208, 32'h20C);
        step(N, N, N, 32'h0);
        chk_out("wrap_issue", Y, 32'hFFFF_FFFC, N, c_NOP, 32'h208, 32'h20C);
        step(N, N, N, 32'h0);
        chk_out("wrap_next", Y, 32'h0, N, c_NOP, 32'h208, 32'h20C);
        step(N, N, N, 32'h0);
        chk_out("wrap_ifid", Y, 32'h4, Y, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0);

        // Reset arriving while the skid holds a captured response
        step(N, Y, N, 32'h0);
        chk_out("rs_stall", N, 32'h8, Y, 32'h1, 32'h0, 32'h4);
        step(Y, Y, N, 32'h0);
        chk({"rs_rst", "_en"}, {31'b0, ImemEn}, 32'h0);
        step(N, N, N, 32'h0);
        chk_out("rs_after", Y, c_RSTPC, N, c_NOP, 32'h0, 32'h0);
        step(N, N, N, 32'h0);
        chk_out("rs_c1", Y, 32'h4, N, c_NOP, 32'h0, 32'h0);
        step(N, N, N, 32'h0);
        chk_out("rs_c2", Y, 32'h8, Y, 32'h1, 32'h0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that feeds the existing execute datapath once the core is pipelined.
- Owns the fetch PC and drives a synchronous instruction ROM (1-cycle read latency).
- Registers fetched instructions into an IF/ID boundary with valid, stall and redirect handling.
- A 1-entry skid buffer absorbs the in-flight ROM response during decode stalls, so sustained throughput is 1 instr/cycle with no duplicate or lost fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction driven when InstrD is not valid (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- StallD  in  1  decode cannot accept; hold IF/ID contents
- Redirect  in  1  taken branch/jump resolved downstream
- RedirectTarget  in  32  new fetch address; bits [1:0] ignored (treated as 00)
- ImemEn  out  1  ROM read enable this cycle
- ImemAddr  out  32  ROM read address (= PCF)
- ImemRData  in  32  ROM data for the address issued in the previous cycle
- InstrD  out  32  instruction at IF/ID
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst high at a clock edge):
  - PCF=RESET_PC; pending=0; skid empty.
  - ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - ImemEn=0 while rst is high.
- Issue: ImemEn = !rst & !StallD & !Redirect; ImemAddr = PCF always.
  - On issue: PCF <= PCF+4 (mod 2^32, wraps silently); pending <= 1; pendPC <= PCF.
  - No issue: pending <= 0.
- Response: when pending=1, ImemRData in this cycle is the instruction at pendPC.
- IF/ID update, in priority order:
  1. Redirect=1:
     - PCF <= {RedirectTarget[31:2],2'b00}; pending <= 0; skid emptied.
     - ValidD <= 0, InstrD <= NOP_INSTR.
     - Any response arriving this cycle is discarded.
     - Redirect overrides StallD.
  2. StallD=1:
     - IF/ID holds all values.
     - If pending: response captured into skid (instr, pendPC).
  3. Otherwise:
     - If skid full: IF/ID <= skid, skid empties.
     - Else if pending: IF/ID <= response, ValidD <= 1.
     - Else: ValidD <= 0, InstrD <= NOP_INSTR.
- Invariant: skid full and pending are never both 1 in a non-stalled cycle. Bench asserts this.
- Latency:
  - PCF issued in cycle n appears at IF/ID in cycle n+2.
  - Redirect in cycle t: target issued t+1, ValidD=1 with PCD=target at t+3 (2 bubbles).
- Stall release: first unstalled cycle loads the skid and issues the next PC simultaneously; zero bubbles.
- Stall with nothing pending (e.g. a back-to-back stall): skid stays unchanged.
- Reset mid-stall or mid-redirect: reset wins; all state returns to reset values.
- When ValidD=0, PCD/PCPlus4D hold their last values; consumers must gate on ValidD.

Decomposition:
- Shared core package (core_pkg):
  - RESET_PC default and NOP_INSTR constant.
  - Struct if_id_t {instr, pc, pc_plus4, valid}, reused by the decode stage.
  - Struct skid_t {instr, pc, full}.
- One natural sub-module: fetch_skid (1-entry capture/drain buffer with full flag).
- PC register and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, no stall, ROM[i]=i*4+1 → InstrD/PCD sequence (1,0),(5,4),(9,8)... with ValidD first high 2 cycles after rst falls; PCPlus4D=PCD+4 throughout.
- StallD high 3 cycles starting while PC 0x8 is in flight → IF/ID frozen at PC 0x4; on release, PC 0x8 then 0xC on consecutive cycles; no duplicates, no gaps, ImemEn low during stall.
- Redirect to 0x0000_0102 with StallD also high → PCF=0x100; 2 cycles of ValidD=0/InstrD=0x13; then PCD=0x100.
- Redirect in the cycle a skid entry is full → skid discarded; the stale PC never appears at IF/ID.
- PCF=0xFFFF_FFFC issue → next PCF=0x0000_0000; PCPlus4D of that instruction = 0x0000_0000.
- rst asserted mid-stream with skid full → next cycle ValidD=0, PCF=RESET_PC; sequence restarts at RESET_PC.
